vga_frame_capture: RTL and testbench
====================================

# vga_frame_capture

Receive-side companion to the VGA pixel output block: samples `vga_h_sync`, `vga_v_sync` and the 1-bit `vga_r/g/b` colour lines in the same clock domain, recovers pixel coordinates, checks the sync timing and locks to it. Once per frame it reports the bounding box of red (bird) pixels and the count of green (pipe) pixels. It sits beside the display path as an on-chip self-check and feeds the game-logic and debug registers.

## Interface
Parameters:
- `H_TOTAL`, 800: clocks per line (h_sync rising edge to next rising edge).
- `V_TOTAL`, 525: lines per frame (v_sync rising edge to next rising edge).
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_OFFSET`, 48: clocks from a registered h_sync rising edge to pixel x=0.
- `V_OFFSET`, 33: lines from a registered v_sync rising edge to line y=0.
- `LOCK_FRAMES`, 2: consecutive good frames required to lock.

Ports:
- `clk` in 1: pixel clock, same clock as the output block.
- `reset` in 1: **asynchronous, active-low** reset.
- `vga_h_sync` in 1: active-low horizontal sync.
- `vga_v_sync` in 1: active-low vertical sync.
- `vga_r`, `vga_g`, `vga_b` in 1 each: pixel colour.
- `pix_x` out 10: recovered x of the current registered pixel.
- `pix_y` out 10: recovered y of the current registered pixel.
- `pix_valid` out 1: current registered pixel is inside the active area.
- `locked` out 1: sync timing is verified.
- `frame_done` out 1: one-cycle pulse when the frame results are updated.
- `bird_found` out 1: the last frame contained at least one red pixel.
- `bird_x_min`, `bird_x_max`, `bird_y_min`, `bird_y_max` out 10 each: red bounding box.
- `green_count` out 19: number of green active pixels in the last frame.
- `line_len` out 10: last measured line length, saturating at 1023.
- `frame_lines` out 10: last measured lines per frame, saturating at 1023.

## Operation
- **Input stage.** All five inputs are registered once (stage s1), then again (s2). Edges are detected from s1 versus s2. The colour used for any pixel is its s1 value.
- **Horizontal counter.** `hcnt` (10 bits) loads 0 on the cycle an h rising edge is detected. Otherwise it increments, saturating at 1023.
- **Vertical counter.** `vcnt` (10 bits) loads 0 on a v rising edge. It increments on each h rising edge, saturating at 1023.
- **Coordinates.**
  - `pix_x = hcnt - H_OFFSET`; `pix_y = vcnt - V_OFFSET`. Both are modulo 1024 and are don't-care when `pix_valid=0`.
  - `pix_valid = locked && hcnt` is in [H_OFFSET, H_OFFSET+H_ACTIVE) `&& vcnt` is in [V_OFFSET, V_OFFSET+V_ACTIVE).
- **Measurement.**
  - On each h rising edge, `line_len <= hcnt+1`, saturating.
  - On each v rising edge, `frame_lines <= vcnt`. A v edge and an h edge in the same cycle are both counted, h first.
  - A line is bad if its measured length ≠ H_TOTAL.
  - A frame is bad if its line count ≠ V_TOTAL or it contains any bad line.
- **Lock FSM.**
  - `SEARCH`: wait for the first v rising edge, then go to `CHECK` with `good=0`.
  - `CHECK`:
    - Each good frame increments `good`.
    - A bad frame resets `good` to 0 and stays in `CHECK`.
    - When `good` reaches `LOCK_FRAMES`, go to `LOCKED`.
  - `LOCKED`: any bad line or bad frame returns to `CHECK` with `good=0`, and `locked` drops the next cycle.
  - Sync stuck: `hcnt` saturating at 1023 in any state goes to `SEARCH`.
- **Per-frame accumulation.** Applies only on `pix_valid` cycles.
  - A red pixel updates running min/max x/y and sets `found_acc`.
  - A green pixel increments `green_acc`.
  - Blue is ignored.
- **Frame end.** On a v rising edge while in `LOCKED`:
  - Latch the accumulators into the bird and green outputs.
  - Pulse `frame_done`.
  - Clear the accumulators: min=1023, max=0, `found=0`, count=0.
- **Unlocked frame end.** On a v rising edge outside `LOCKED`, clear the accumulators only. Outputs hold their values and there is no pulse.
- **Lock loss mid-frame.** The partial frame is discarded at the next v edge.

## Timing
- Reset values:
  - All counters and measurements 0.
  - FSM = `SEARCH`.
  - `locked`, `pix_valid`, `frame_done`, `bird_found` = 0.
  - `bird_x_min`/`bird_y_min` = 1023; `bird_x_max`/`bird_y_max` = 0; `green_count` = 0.
- Latency: a pin value at clock n appears in s1 at n+1. `pix_x`/`pix_y`/`pix_valid` describe that s1 sample in the same cycle.
- `frame_done` is asserted in the cycle after the v-edge detect cycle. The result outputs are valid in that cycle and hold until the next pulse.
- `locked` rises the cycle after the `LOCK_FRAMES`-th good v edge is detected.
- Reset asserted mid-frame clears state immediately. Re-lock needs a v edge plus `LOCK_FRAMES` full frames.

## Structure
- Shared package `vga_timing_pkg`:
  - 640x480 timing constants: H_TOTAL, V_TOTAL, H_ACTIVE, V_ACTIVE, H_OFFSET, V_OFFSET.
  - Lock-state enum {SEARCH, CHECK, LOCKED}.
  - These are also used by the sync generator.
- One sub-module `vga_bbox_accum`: min/max/found/count accumulator with clear and latch strobes.

## Test plan
- Reset, then an ideal 800x525 stimulus → `locked=0` through the first v edge; `locked=1` one cycle after the 3rd v rising edge (2 good frames); `line_len=800`, `frame_lines=525`.
- Locked, red square at x 310..330, y 230..250 → next `frame_done`: `bird_found=1` and box (310,330,230,250).
- Locked, green block x 10..90, y 0..479 plus no red → `green_count=38880`, `bird_found=0`, box (1023,0,1023,0).
- Locked, one line shortened to 799 clocks → `locked` low one cycle after that h edge; no `frame_done` for that frame; re-locks after 2 good frames.
- h_sync held high 1100 clocks → FSM in `SEARCH`, `pix_valid=0`; recovery on restored sync.
- Reset pulsed low mid-frame while locked → all outputs at reset values immediately; frame results unchanged until re-lock.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants and lock-state encoding shared by the sync
// generator and the frame-capture checker.
package vga_timing_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_OFFSET = 48;
  localparam int V_OFFSET = 33;

  localparam int CNT_W   = 10;
  localparam int GREEN_W = 19;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/vga_frame_capture_if.sv
// VGA pin bundle: two active-low syncs plus 1-bit colour lines.
interface vga_frame_capture_if;

  logic vga_h_sync;
  logic vga_v_sync;
  logic vga_r;
  logic vga_g;
  logic vga_b;

  modport master (output vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b);
  modport slave  (input  vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b);

endinterface

// File: rtl/vga_bbox_accum.sv
// Per-frame red bounding box and green pixel count, with a clear strobe for the
// running accumulators and a latch strobe that publishes them.
module vga_bbox_accum
  import vga_timing_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               red,
  input  logic               green,
  input  logic [CNT_W-1:0]   x,
  input  logic [CNT_W-1:0]   y,
  input  logic               clr,
  input  logic               latch,
  output logic               found,
  output logic [CNT_W-1:0]   x_min,
  output logic [CNT_W-1:0]   x_max,
  output logic [CNT_W-1:0]   y_min,
  output logic [CNT_W-1:0]   y_max,
  output logic [GREEN_W-1:0] green_count
);

  logic               found_acc;
  logic [CNT_W-1:0]   xmin_acc, xmax_acc, ymin_acc, ymax_acc;
  logic [GREEN_W-1:0] green_acc;

  // Running accumulators; a clear discards any pixel in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      found_acc <= 1'b0;
      xmin_acc  <= '1;
      xmax_acc  <= '0;
      ymin_acc  <= '1;
      ymax_acc  <= '0;
      green_acc <= '0;
    end else if (clr) begin
      found_acc <= 1'b0;
      xmin_acc  <= '1;
      xmax_acc  <= '0;
      ymin_acc  <= '1;
      ymax_acc  <= '0;
      green_acc <= '0;
    end else if (pix_valid) begin
      if (red) begin
        found_acc <= 1'b1;
        if (x < xmin_acc) xmin_acc <= x;
        if (x > xmax_acc) xmax_acc <= x;
        if (y < ymin_acc) ymin_acc <= y;
        if (y > ymax_acc) ymax_acc <= y;
      end
      if (green) green_acc <= green_acc + 1'b1;
    end
  end

  // Published results hold between latch strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      found       <= 1'b0;
      x_min       <= '1;
      x_max       <= '0;
      y_min       <= '1;
      y_max       <= '0;
      green_count <= '0;
    end else if (latch) begin
      found       <= found_acc;
      x_min       <= xmin_acc;
      x_max       <= xmax_acc;
      y_min       <= ymin_acc;
      y_max       <= ymax_acc;
      green_count <= green_acc;
    end
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Receive-side VGA checker: recovers pixel coordinates from the syncs, verifies
// line/frame timing, locks, and reports per-frame bird box and pipe pixel count.
module vga_frame_capture #(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int H_OFFSET    = vga_timing_pkg::H_OFFSET,
  parameter int V_OFFSET    = vga_timing_pkg::V_OFFSET,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_capture_if.slave  vga,
  output logic [9:0]          pix_x,
  output logic [9:0]          pix_y,
  output logic                pix_valid,
  output logic                locked,
  output logic                frame_done,
  output logic                bird_found,
  output logic [9:0]          bird_x_min,
  output logic [9:0]          bird_x_max,
  output logic [9:0]          bird_y_min,
  output logic [9:0]          bird_y_max,
  output logic [18:0]         green_count,
  output logic [9:0]          line_len,
  output logic [9:0]          frame_lines
);
  import vga_timing_pkg::*;

  localparam logic [9:0] CNT_MAX   = 10'h3FF;
  localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] H_OFF_C   = 10'(H_OFFSET);
  localparam logic [9:0] H_END_C   = 10'(H_OFFSET + H_ACTIVE);
  localparam logic [9:0] V_OFF_C   = 10'(V_OFFSET);
  localparam logic [9:0] V_END_C   = 10'(V_OFFSET + V_ACTIVE);
  localparam logic [7:0] LOCK_C    = 8'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

  logic h_p1, v_p1, r_p1, g_p1, b_p1;
  logic h_p2, v_p2;
  logic h_rise, v_rise;
  logic [9:0] hcnt, vcnt, lines_now;
  logic bad_acc, line_bad, frame_bad, latch;
  logic [7:0] good;
  lock_state_t state;
  logic unused_blue;

  // Stage 1 / stage 2: syncs idle high out of reset so no edge is seen on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_p1 <= 1'b1;
      v_p1 <= 1'b1;
      r_p1 <= 1'b0;
      g_p1 <= 1'b0;
      b_p1 <= 1'b0;
      h_p2 <= 1'b1;
      v_p2 <= 1'b1;
    end else begin
      h_p1 <= vga.vga_h_sync;
      v_p1 <= vga.vga_v_sync;
      r_p1 <= vga.vga_r;
      g_p1 <= vga.vga_g;
      b_p1 <= vga.vga_b;
      h_p2 <= h_p1;
      v_p2 <= v_p1;
    end
  end

  // Blue is captured with the other colours but takes no part in detection.
  assign unused_blue = b_p1;

  assign h_rise    = h_p1 & ~h_p2;
  assign v_rise    = v_p1 & ~v_p2;
  assign lines_now = h_rise ? sat_inc(vcnt) : vcnt;
  assign line_bad  = h_rise && (sat_inc(hcnt) != H_TOTAL_C);
  assign frame_bad = (lines_now != V_TOTAL_C) || bad_acc || line_bad;
  assign latch     = v_rise && (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      bad_acc     <= 1'b0;
    end else begin
      hcnt <= h_rise ? 10'd0 : sat_inc(hcnt);
      if (v_rise)      vcnt <= '0;
      else if (h_rise) vcnt <= sat_inc(vcnt);
      if (h_rise) line_len <= sat_inc(hcnt);
      if (v_rise) frame_lines <= lines_now;
      if (v_rise)        bad_acc <= 1'b0;
      else if (line_bad) bad_acc <= 1'b1;
    end
  end

  // Lock FSM; a saturated line counter means sync has stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      good       <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch;
      if (hcnt == CNT_MAX) begin
        state  <= SEARCH;
        good   <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (v_rise) begin
              state <= CHECK;
              good  <= '0;
            end
          end
          CHECK: begin
            if (v_rise) begin
              if (frame_bad) begin
                good <= '0;
              end else if (good + 8'd1 >= LOCK_C) begin
                state  <= LOCKED;
                good   <= '0;
                locked <= 1'b1;
              end else begin
                good <= good + 8'd1;
              end
            end
          end
          LOCKED: begin
            if (line_bad || (v_rise && frame_bad)) begin
              state  <= CHECK;
              good   <= '0;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pix_x     = hcnt - H_OFF_C;
  assign pix_y     = vcnt - V_OFF_C;
  assign pix_valid = locked && (hcnt >= H_OFF_C) && (hcnt < H_END_C)
                     && (vcnt >= V_OFF_C) && (vcnt < V_END_C);

  vga_bbox_accum u_accum (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .red         (r_p1),
    .green       (g_p1),
    .x           (pix_x),
    .y           (pix_y),
    .clr         (v_rise),
    .latch       (latch),
    .found       (bird_found),
    .x_min       (bird_x_min),
    .x_max       (bird_x_max),
    .y_min       (bird_y_min),
    .y_max       (bird_y_max),
    .green_count (green_count)
  );

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a shrunken 64x30 raster so that
// many frames fit in a short run.
module tb_vga_frame_capture;

  localparam int HT = 64, VT = 30, HA = 40, VA = 20, HO = 8, VO = 4, LF = 2;
  localparam int XB = HO + 1;  // generator column that lands on pix_x = 0

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic        pix_valid, locked, frame_done, bird_found;
  logic [9:0]  bird_x_min, bird_x_max, bird_y_min, bird_y_max;
  logic [18:0] green_count;
  logic [9:0]  line_len, frame_lines;

  vga_frame_capture_if vif ();

  vga_frame_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_OFFSET(HO), .V_OFFSET(VO), .LOCK_FRAMES(LF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vga         (vif),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .locked      (locked),
    .frame_done  (frame_done),
    .bird_found  (bird_found),
    .bird_x_min  (bird_x_min),
    .bird_x_max  (bird_x_max),
    .bird_y_min  (bird_y_min),
    .bird_y_max  (bird_y_max),
    .green_count (green_count),
    .line_len    (line_len),
    .frame_lines (frame_lines)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int gh = 0, gv = 0, pat = 0, fd_count = 0, fd_mark = 0;
  bit short_req = 1'b0;
  int short_line = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Returns {r,g,b} for generator position (h, v) under pattern p.
  function automatic logic [2:0] colour(input int h, input int v, input int p);
    int x, y;
    logic r, g, b;
    x = h - XB;
    y = v - VO;
    r = 1'b0; g = 1'b0; b = 1'b0;
    case (p)
      1: begin
        r = (x >= 10 && x <= 15 && y >= 5 && y <= 8) || (x == 12 && y == -1) || (x == 12 && y == VA);
        b = (x == 20 && y == 10);
      end
      2: g = (x >= 2 && x <= 9) || (x == -1) || (x == HA);
      3: r = (x == 0 && y == VA - 1) || (x == HA - 1 && y == 0);
      default: ;
    endcase
    return {r, g, b};
  endfunction

  task automatic step();
    logic [2:0] c;
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_count++;
    c = colour(gh, gv, pat);
    vif.vga_h_sync = (gh < HT - 8);
    vif.vga_v_sync = (gv < VT - 2);
    vif.vga_r = c[2];
    vif.vga_g = c[1];
    vif.vga_b = c[0];
    if (gh == HT - 1 || (short_req && gv == short_line && gh == HT - 2)) begin
      if (gh == HT - 2) short_req = 1'b0;
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
  endtask

  // Steps until the generator has driven position (th, tv).
  task automatic run_to(input int th, input int tv);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * HT * VT && !hit; i++) begin
      hit = (gh == th && gv == tv);
      step();
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $error("FAIL run_to: position (%0d,%0d) never driven", th, tv);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    vif.vga_h_sync = 1'b1;
    vif.vga_v_sync = 1'b1;
    vif.vga_r = 1'b0;
    vif.vga_g = 1'b0;
    vif.vga_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_bird_found", bird_found, 0);
    check("rst_x_min", bird_x_min, 1023);
    check("rst_y_max", bird_y_max, 0);
    check("rst_line_len", line_len, 0);

    // Ideal raster with the red square from the start; lock on the third v edge.
    gh = 0; gv = 25; pat = 1;
    reset = 1'b1;
    run_to(0, 0); step();
    check("e1_locked", locked, 0);
    run_to(0, 0); step(); step();
    check("e2_locked", locked, 0);
    run_to(0, 0); step();
    check("e3_locked_early", locked, 0);
    step();
    check("e3_locked", locked, 1);
    check("line_len", line_len, HT);
    check("frame_lines", frame_lines, VT);

    // Right edge of the active window.
    run_to(XB + HA - 1, VO + 6); step();
    check("edge_valid", pix_valid, 1);
    check("edge_pix_x", pix_x, HA - 1);
    check("edge_pix_y", pix_y, 6);
    step();
    check("past_edge_valid", pix_valid, 0);
    check("no_fd_before_lock", fd_count, 0);

    // Red frame result, then switch to the green pattern.
    run_to(0, 0); pat = 2; step();
    check("e4_fd_early", frame_done, 0);
    step();
    check("e4_fd", frame_done, 1);
    check("e4_fd_count", fd_count, 1);
    check("red_found", bird_found, 1);
    check("red_x_min", bird_x_min, 10);
    check("red_x_max", bird_x_max, 15);
    check("red_y_min", bird_y_min, 5);
    check("red_y_max", bird_y_max, 8);
    step();
    check("e4_fd_pulse", frame_done, 0);

    run_to(0, 0); pat = 0; step(); step();
    check("e5_fd", frame_done, 1);
    check("green_count", green_count, 160);
    check("green_found", bird_found, 0);
    check("green_x_min", bird_x_min, 1023);
    check("green_x_max", bird_x_max, 0);
    check("green_y_min", bird_y_min, 1023);
    check("green_y_max", bird_y_max, 0);
    fd_mark = fd_count;

    // Shortened line drops lock right after its closing h edge.
    short_line = 10; short_req = 1'b1;
    run_to(0, short_line + 1); step();
    check("short_locked_early", locked, 1);
    step();
    check("short_locked", locked, 0);
    run_to(0, 0); step(); step();
    check("e6_locked", locked, 0);
    run_to(0, 0); step(); step();
    check("e7_locked", locked, 0);
    run_to(0, 0); step();
    check("e8_locked_early", locked, 0);
    step();
    check("e8_relocked", locked, 1);
    check("no_fd_unlocked", fd_count, fd_mark);
    check("green_held", green_count, 160);

    // h_sync stuck high.
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_count++;
      vif.vga_h_sync = 1'b1;
      vif.vga_v_sync = 1'b1;
      vif.vga_r = 1'b0;
      vif.vga_g = 1'b0;
      vif.vga_b = 1'b0;
      if (i == 500) check("hold_still_locked", locked, 1);
    end
    check("stuck_locked", locked, 0);
    check("stuck_pix_valid", pix_valid, 0);

    gh = 0; gv = 1; pat = 1;
    run_to(0, 0);
    run_to(0, 0); step(); step();
    check("r2_locked", locked, 0);
    run_to(0, 0); step();
    check("r3_locked_early", locked, 0);
    step();
    check("r3_locked", locked, 1);
    run_to(0, 0); step(); step();
    check("r4_fd", frame_done, 1);
    check("r4_x_min", bird_x_min, 10);
    check("r4_y_max", bird_y_max, 8);

    // Reset pulsed mid-frame while locked.
    run_to(20, 10);
    reset = 1'b0;
    #1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_found", bird_found, 0);
    check("mid_rst_x_min", bird_x_min, 1023);
    check("mid_rst_x_max", bird_x_max, 0);
    check("mid_rst_y_min", bird_y_min, 1023);
    check("mid_rst_green", green_count, 0);
    check("mid_rst_line_len", line_len, 0);
    check("mid_rst_frame_lines", frame_lines, 0);
    repeat (3) step();
    reset = 1'b1;
    pat = 3;
    run_to(0, 0); step(); step();
    check("q1_locked", locked, 0);
    run_to(0, 0); step(); step();
    check("q2_found", bird_found, 0);
    run_to(0, 0); step(); step();
    check("q3_locked", locked, 1);
    check("q3_x_min_held", bird_x_min, 1023);
    run_to(0, 0); step(); step();
    check("q4_fd", frame_done, 1);
    check("corner_found", bird_found, 1);
    check("corner_x_min", bird_x_min, 0);
    check("corner_x_max", bird_x_max, HA - 1);
    check("corner_y_min", bird_y_min, 0);
    check("corner_y_max", bird_y_max, VA - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
